// File: rtl/dsp_arb.sv
// ============================================================================
// Module   : dsp_arb
// Purpose  : Round-robin arbiter sharing the 8-digit seven-segment display
//            between NREQ requesters, with a minimum hold time counted in
//            1 kHz ticks. The owner's 64-bit image is registered onto dout.
// Options  : `define DSP_ARB_PRIO0_EN makes requester 0 urgent (preempts on
//            the rising edge of req[0], never preempted while it holds).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dsp_arb #(
  parameter int          NREQ       = 4,
  parameter int          HOLD_TICKS = 500,
  parameter logic [63:0] BLANK      = 64'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*64-1:0] data,
  output logic [NREQ-1:0]    gnt,
  output logic [2:0]         owner,
  output logic               busy,
  output logic               swap,
  output logic [63:0]        dout
);

  localparam logic [1:0]      S_IDLE   = 2'd0;
  localparam logic [1:0]      S_HOLD   = 2'd1;
  localparam logic [1:0]      S_OPEN   = 2'd2;
  localparam logic [15:0]     HOLD_MAX = 16'(HOLD_TICKS);
  localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [1:0]      S_AFTER_GRANT = (HOLD_TICKS == 0) ? S_OPEN : S_HOLD;

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [2:0]      owner_q, owner_d;
  logic [2:0]      ptr_q, ptr_d;
  logic            busy_q, busy_d;
  logic            swap_q, swap_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [63:0]     dout_q, dout_d;

  logic [NREQ-1:0] others;
  logic            owner_req;
  logic            prio_take;
  logic            owner_locked;

  // First requester after 'from' in circular order; 'from' itself comes last.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r,
                                         input logic [2:0] from);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = from;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(from) + k) % NREQ;
      if (!found && r[idx]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign others    = req & ~gnt_q;
  assign owner_req = |(req & gnt_q);

`ifdef DSP_ARB_PRIO0_EN
  logic req0_q;

  // Previous req[0] level, used to detect the urgent request edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) req0_q <= 1'b0;
    else     req0_q <= req[0];
  end

  assign prio_take    = req[0] & ~req0_q & (owner_q != 3'd0);
  assign owner_locked = (owner_q == 3'd0);
`else
  assign prio_take    = 1'b0;
  assign owner_locked = 1'b0;
`endif

  // Arbitration state machine: grant, hold, preempt and release decisions.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    swap_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          owner_d = rr_pick(req, ptr_q);
          ptr_d   = owner_d;
          gnt_d   = ONE_HOT0 << owner_d;
          busy_d  = 1'b1;
          swap_d  = 1'b1;
          cnt_d   = 16'd0;
          state_d = S_AFTER_GRANT;
        end
      end
      S_HOLD, S_OPEN: begin
        if (!owner_req) begin
          // Release wins over everything; owner stays as the RR pointer.
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (prio_take) begin
          owner_d = 3'd0;
          ptr_d   = 3'd0;
          gnt_d   = ONE_HOT0;
          swap_d  = 1'b1;
          cnt_d   = 16'd0;
          state_d = S_AFTER_GRANT;
        end else if (state_q == S_HOLD) begin
          if (tick) begin
            if (cnt_q < HOLD_MAX) cnt_d = cnt_q + 16'd1;
            if (cnt_d == HOLD_MAX) state_d = S_OPEN;
          end
        end else if ((|others) && !owner_locked) begin
          // Direct hand-over, no dead cycle; a coincident tick is dropped.
          owner_d = rr_pick(others, ptr_q);
          ptr_d   = owner_d;
          gnt_d   = ONE_HOT0 << owner_d;
          swap_d  = 1'b1;
          cnt_d   = 16'd0;
          state_d = S_AFTER_GRANT;
        end
      end
      default: begin
        gnt_d   = '0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Image of the registered owner, or BLANK while nobody holds the display.
  always_comb begin
    dout_d = BLANK;
    for (int i = 0; i < NREQ; i++) begin
      if ((|gnt_q) && (owner_q == 3'(i))) dout_d = data[64*i +: 64];
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= 3'd0;
      ptr_q   <= 3'(NREQ - 1);
      busy_q  <= 1'b0;
      swap_q  <= 1'b0;
      cnt_q   <= 16'd0;
      dout_q  <= BLANK;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      swap_q  <= swap_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = busy_q;
  assign swap  = swap_q;
  assign dout  = dout_q;

endmodule

`default_nettype wire

// File: tb/tb_dsp_arb.sv
// ============================================================================
// Module   : tb_dsp_arb
// Purpose  : Self-checking bench for dsp_arb (NREQ=4, HOLD_TICKS=3, BLANK=0,
//            tick every 10 cycles) against a behavioural ownership model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsp_arb;

  localparam int          NREQ  = 4;
  localparam int          HOLD  = 3;
  localparam logic [63:0] BLANK = 64'h0;

  logic               clk = 1'b0;
  logic               rst;
  logic               tick;
  logic [NREQ-1:0]    req;
  logic [NREQ*64-1:0] data;
  logic [NREQ-1:0]    gnt;
  logic [2:0]         owner;
  logic               busy;
  logic               swap;
  logic [63:0]        dout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: who owns the display and how long it has held it.
  int          m_own;
  int          m_last;
  int          m_ptr;
  int          m_held;
  bit          m_swap;
  bit          m_r0_prev;
  logic [63:0] m_dout;

  dsp_arb #(.NREQ(NREQ), .HOLD_TICKS(HOLD), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .tick(tick), .req(req), .data(data),
    .gnt(gnt), .owner(owner), .busy(busy), .swap(swap), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r, input int from);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(from + k) % NREQ]) return (from + k) % NREQ;
    end
    return from;
  endfunction

  task automatic m_reset();
    m_own = -1; m_last = 0; m_ptr = NREQ - 1; m_held = 0;
    m_swap = 0; m_r0_prev = 0; m_dout = BLANK;
  endtask

  task automatic model_step(input logic [NREQ-1:0] r, input bit t,
                            input logic [NREQ*64-1:0] d);
    logic [63:0]     nd;
    logic [NREQ-1:0] oth;
    bit              locked;
    nd     = (m_own >= 0) ? d[64*m_own +: 64] : BLANK;
    m_swap = 0;
    locked = 0;
`ifdef DSP_ARB_PRIO0_EN
    locked = (m_own == 0);
`endif
    if (m_own < 0) begin
      if (r != '0) begin m_own = pick(r, m_ptr); m_held = 0; m_swap = 1; end
    end else if (!r[m_own]) begin
      m_own = -1;
`ifdef DSP_ARB_PRIO0_EN
    end else if (r[0] && !m_r0_prev && m_own != 0) begin
      m_own = 0; m_held = 0; m_swap = 1;
`endif
    end else if (m_held < HOLD) begin
      if (t) m_held++;
    end else begin
      oth = r;
      oth[m_own] = 1'b0;
      if (oth != '0 && !locked) begin
        m_own = pick(oth, m_own); m_held = 0; m_swap = 1;
      end
    end
    if (m_own >= 0) begin m_ptr = m_own; m_last = m_own; end
    m_r0_prev = r[0];
    m_dout    = nd;
  endtask

  task automatic check_all();
    logic [NREQ-1:0] eg;
    eg = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
    chk("gnt",   64'(gnt),   64'(eg));
    chk("owner", 64'(owner), 64'(m_last));
    chk("busy",  64'(busy),  64'(m_own >= 0));
    chk("swap",  64'(swap),  64'(m_swap));
    chk("dout",  dout,       m_dout);
  endtask

  // One clock: advance the model, let the edge happen, compare, plan next tick.
  task automatic cycle();
    model_step(req, tick, data);
    @(posedge clk);
    #1;
    cyc++;
    check_all();
    tick = ((cyc % 10) == 9);
  endtask

  initial begin
    int sw_own[$];
    int sw_cyc[$];
    int n;

    rst = 1'b1; tick = 1'b0; req = '0; data = '0;
    m_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_owner", 64'(owner), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_swap", 64'(swap), 64'h0);
    chk("rst_dout", dout, BLANK);
    rst = 1'b0;

    // First grant: requesters 1 and 2 ask, requester 1 wins (pointer at 3).
    for (int i = 0; i < NREQ; i++) data[64*i +: 64] = {$urandom, $urandom};
    data[64*2 +: 64] = 64'h0102030405060708;
    req = 4'b0110;
    cycle();
    chk("t1_gnt", 64'(gnt), 64'h2);
    chk("t1_swap", 64'(swap), 64'h1);
    cycle();
    chk("t1_dout", dout, data[64*1 +: 64]);
    chk("t1_busy", 64'(busy), 64'h1);
    chk("t1_swap_once", 64'(swap), 64'h0);

    // Hold-time preemption: requester 3 waits until 3 ticks are counted.
    req = 4'b1010;
    n = 0;
    while (gnt == 4'b0010 && n < 60) begin cycle(); n++; end
    chk("t2_timeout", 64'(n < 60), 64'h1);
    chk("t2_gnt", 64'(gnt), 64'h8);
    chk("t2_swap", 64'(swap), 64'h1);

    // Release with nobody else waiting.
    req = 4'b0000;
    cycle();
    chk("t3_busy", 64'(busy), 64'h0);
    chk("t3_owner", 64'(owner), 64'h3);
    cycle();
    chk("t3_dout", dout, 64'h0);

    // Fairness: everybody requests constantly.
    req = 4'b1111;
    for (int i = 0; i < 200 && sw_own.size() < 6; i++) begin
      data[64*(i % NREQ) +: 64] = {$urandom, $urandom};
      cycle();
      if (swap) begin sw_own.push_back(int'(owner)); sw_cyc.push_back(cyc); end
    end
    chk("fair_count", 64'(sw_own.size()), 64'd6);
    if (sw_own.size() == 6) begin
      chk("fair_first", 64'(sw_own[0]), 64'h0);
      for (int i = 1; i < 6; i++) begin
        chk("fair_order", 64'(sw_own[i]), 64'((sw_own[i-1] + 1) % NREQ));
        if (i >= 2) chk("fair_hold", 64'(sw_cyc[i] - sw_cyc[i-1]), 64'd30);
      end
    end

    // Release in the same cycle as a tick.
    n = 0;
    while (!tick && n < 20) begin cycle(); n++; end
    chk("t5_tick_seen", 64'(tick), 64'h1);
    req = 4'b0000;
    cycle();
    chk("t5_busy", 64'(busy), 64'h0);
    chk("t5_gnt", 64'(gnt), 64'h0);

    // Asynchronous reset in the middle of a hold.
    req = 4'b0100;
    cycle(); cycle(); cycle();
    chk("t6_pre_busy", 64'(busy), 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_gnt", 64'(gnt), 64'h0);
    chk("t6_async_dout", dout, 64'h0);
    chk("t6_async_busy", 64'(busy), 64'h0);
    #1 rst = 1'b0;
    m_reset();
    req = 4'b0000;
    cycle(); cycle();

`ifdef DSP_ARB_PRIO0_EN
    // Urgent requester 0 takes over from requester 2 during its hold.
    req = 4'b0100;
    cycle();
    n = 0;
    while (!tick && n < 20) begin cycle(); n++; end
    cycle();
    req = 4'b1101;
    cycle();
    chk("p_gnt", 64'(gnt), 64'h1);
    chk("p_swap", 64'(swap), 64'h1);
    for (int i = 0; i < 60; i++) begin
      cycle();
      chk("p_locked", 64'(gnt), 64'h1);
    end
    req = 4'b0000;
    cycle(); cycle();
`endif

    // Randomized traffic checked against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) req = 4'($urandom);
      if ($urandom_range(0, 2) == 0) data[64*$urandom_range(0, NREQ-1) +: 64] = {$urandom, $urandom};
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
